// File: rtl/uart_sched_pkg.sv
// Shared constants and types for the UART transmit scheduler.
// Latency: none (declarations only).
// Backpressure: n/a.
package uart_sched_pkg;

  localparam int         FIFO_DEPTH = 8;
  localparam int         PTR_W      = 3;
  localparam int         LEVEL_W    = 4;
  localparam logic [7:0] LF_CHAR    = 8'h0A;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    GUARD = 2'd2
  } drain_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Eight-entry in-order byte FIFO with registered occupancy.
// Latency: a pushed byte is visible at dout one edge later; there is no bypass.
// Backpressure: push is ignored when full and pop is ignored when empty.
module uart_tx_fifo
  import uart_sched_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  logic [7:0]         din,
  output logic [7:0]         dout,
  output logic [LEVEL_W-1:0] level,
  output logic               full,
  output logic               empty
);

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LEVEL_W'(FIFO_DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy move together on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      level <= level + LEVEL_W'(do_push) - LEVEL_W'(do_pop);
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Two-requester round-robin byte scheduler feeding a UART through an 8-deep FIFO.
// Latency: a byte pushed at edge N raises uart_we after edge N+1 at the earliest; GUARD_CYCLES idle cycles follow each write.
// Backpressure: reqN_ready drops when the FIFO is full (start-of-cycle level) or the other requester holds the grant.
// Optional feature: UART_SCHED_LINE_LOCK_EN keeps the grant on one requester until it pushes LF.
module uart_tx_sched
  import uart_sched_pkg::*;
#(
  parameter int GUARD_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0_valid,
  input  logic [7:0]         req0_data,
  output logic               req0_ready,
  input  logic               req1_valid,
  input  logic [7:0]         req1_data,
  output logic               req1_ready,
  input  logic               uart_tdre,
  output logic               uart_we,
  output logic [7:0]         uart_di,
  output logic [LEVEL_W-1:0] fifo_level,
  output logic               busy
);

  drain_state_t       state;
  logic [7:0]         guard_cnt;
  logic               last_grant;
  logic               grant;
  logic               push;
  logic               pop;
  logic [7:0]         push_data;
  logic [7:0]         fifo_head;
  logic               fifo_full;
  logic               fifo_empty;
  logic [LEVEL_W-1:0] level_nxt;

`ifdef UART_SCHED_LINE_LOCK_EN
  logic lock_active;
  logic lock_owner;
`endif

  // Grant from registered state only: lone requester wins, a tie goes to the one not served last.
  always_comb begin
    grant = ~last_grant;
    if (req0_valid && !req1_valid)      grant = 1'b0;
    else if (req1_valid && !req0_valid) grant = 1'b1;
`ifdef UART_SCHED_LINE_LOCK_EN
    if (lock_active) grant = lock_owner;
`endif
  end

  assign req0_ready = !grant && !fifo_full;
  assign req1_ready =  grant && !fifo_full;
  assign push       = grant ? (req1_valid && req1_ready) : (req0_valid && req0_ready);
  assign push_data  = grant ? req1_data : req0_data;
  assign pop        = (state == WRITE);
  assign level_nxt  = fifo_level + LEVEL_W'(push) - LEVEL_W'(pop);

  uart_tx_fifo u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (push_data),
    .dout  (fifo_head),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Remember who was served last (and, with line lock, who owns the line until LF).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant  <= 1'b1;
`ifdef UART_SCHED_LINE_LOCK_EN
      lock_active <= 1'b0;
      lock_owner  <= 1'b0;
`endif
    end else if (push) begin
      last_grant <= grant;
`ifdef UART_SCHED_LINE_LOCK_EN
      if (push_data == LF_CHAR) begin
        lock_active <= 1'b0;
      end else begin
        lock_active <= 1'b1;
        lock_owner  <= grant;
      end
`endif
    end
  end

  // Drain FSM: one write strobe per byte, then a fixed guard gap before tdre is trusted again.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      guard_cnt <= '0;
      uart_we   <= 1'b0;
      uart_di   <= 8'h00;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty && uart_tdre) begin
            state   <= WRITE;
            uart_we <= 1'b1;
            uart_di <= fifo_head;
            busy    <= 1'b1;
          end else begin
            busy    <= (level_nxt != '0);
          end
        end
        WRITE: begin
          uart_we <= 1'b0;
          if (GUARD_CYCLES == 0) begin
            state <= IDLE;
            busy  <= (level_nxt != '0);
          end else begin
            state     <= GUARD;
            guard_cnt <= 8'(GUARD_CYCLES - 1);
            busy      <= 1'b1;
          end
        end
        GUARD: begin
          if (guard_cnt == '0) begin
            state <= IDLE;
            busy  <= (level_nxt != '0);
          end else begin
            guard_cnt <= guard_cnt - 8'd1;
            busy      <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          uart_we <= 1'b0;
          busy    <= (level_nxt != '0);
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 SHALL have ports, one per line (name  direction  width  meaning):
  clk  input  1  system clock, rising-edge, single clock domain
  reset  input  1  asynchronous, active-high reset
  req0_valid  input  1  requester 0 offers a byte
  req0_data  input  8  requester 0 byte
  req0_ready  output  1  requester 0 byte accepted this cycle when valid&ready
  req1_valid  input  1  requester 1 offers a byte
  req1_data  input  8  requester 1 byte
  req1_ready  output  1  requester 1 byte accepted this cycle when valid&ready
  uart_tdre  input  1  UART transmit data register empty
  uart_we  output  1  one-cycle write strobe to UART data register
  uart_di  output  8  byte presented with uart_we
  fifo_level  output  4  current FIFO occupancy, 0..8
  busy  output  1  FIFO non-empty or drain FSM not IDLE
REQ-002 SHALL have one parameter, one per line (name, default, meaning):
  GUARD_CYCLES, 2, idle cycles after each uart_we before tdre is sampled again

Function
REQ-003 SHALL buffer accepted bytes in an 8-entry FIFO, in order, no bypass path.
REQ-004 SHALL accept at most one byte per cycle, from the granted requester only.
REQ-005 Grant SHALL be combinational from registered state: round-robin; on a tie, the requester not granted last wins.
REQ-006 reqN_ready SHALL equal (grant==N) && (fifo_level<8); both readys are never high together.
REQ-007 When full, both readys SHALL be low; a pop in the same cycle does not enable a push (push checks start-of-cycle level).
REQ-008 Simultaneous push and pop at level 1..7 SHALL leave fifo_level unchanged.
REQ-009 Drain FSM SHALL have states IDLE, WRITE and GUARD.
REQ-010 IDLE->WRITE SHALL occur when the FIFO is non-empty and uart_tdre is 1.
REQ-011 In WRITE, uart_we SHALL be 1 for exactly one cycle with uart_di = FIFO head; the head is popped in the same cycle.
REQ-012 WRITE->GUARD SHALL be unconditional; GUARD SHALL last GUARD_CYCLES cycles and then return to IDLE.
REQ-013 A byte pushed into an empty FIFO at edge N SHALL produce uart_we no earlier than the cycle after edge N+1, given uart_tdre=1.
REQ-014 uart_we and uart_di SHALL be registered outputs; uart_di holds its last value when uart_we is 0.
REQ-015 fifo_level and busy SHALL be registered and updated on the same edge as the FIFO pointers.

Reset
REQ-016 reset SHALL asynchronously clear FIFO pointers, fifo_level=0, uart_we=0, uart_di=8'h00, busy=0, FSM=IDLE, last grant=1 (requester 0 wins first), lock cleared.
REQ-017 Reset mid-drain SHALL discard all buffered bytes; no uart_we is issued until new data arrives after reset release.

Configuration
REQ-018 Macro UART_SCHED_LINE_LOCK_EN SHALL, when defined, hold the grant on the current winner from its first accepted byte until it pushes 8'h0A (LF). Grant then re-arbitrates; the other requester waits even if the holder drops valid.
REQ-019 Without UART_SCHED_LINE_LOCK_EN, SHALL re-arbitrate every cycle per REQ-005 with no lock state.

Structure
REQ-020 Shared package uart_sched_pkg SHALL hold FIFO_DEPTH=8, the FSM state enum and LF_CHAR=8'h0A.
REQ-021 FIFO storage and pointers SHALL be a sub-module uart_tx_fifo (push, pop, data in/out, level, full, empty); arbitration and FSM stay in uart_tx_sched.

Verification
REQ-022 Bench SHALL cover:
  - req0 pushes 8'h41, uart_tdre=1 -> one uart_we pulse, uart_di=8'h41, level returns to 0, busy drops after GUARD.
  - Both valid continuously (no lock), req0=8'h30.., req1=8'h61.. -> accepted order alternates 30,61,31,62...; first is req0.
  - uart_tdre=0, req0 pushes 10 bytes -> level saturates at 8, req0_ready=0; raise tdre -> 8 bytes out in order, 2 GUARD cycles apart.
  - With lock: req0 sends "AB",0x0A while req1 valid -> req1_ready=0 until 0x0A accepted; req1 then granted.
  - Assert reset with level=5 during WRITE -> uart_we=0 immediately, level=0; no further writes after release.
  - Full FIFO with pop and push offered same cycle -> push refused, level 7 next cycle.
